opa_skid_stage: RTL

//  Decode->execute stage for operand A. Consumes the 2-bit opasel code from the operand-A

---
 rtl/opa_skid_stage_pkg.sv | 27 ++
 rtl/opa_skid_stage_if.sv | 24 ++
 rtl/opa_skid_stage_resolve.sv | 38 +++
 rtl/opa_skid_stage.sv | 112 +++++++++++
 4 files changed

// File: rtl/opa_skid_stage_pkg.sv
// Shared types for the operand-A decode->execute stage: select codes, widths and the
// beat record held in both skid-buffer entries.
package opa_skid_stage_pkg;

  localparam int OPA_XLEN      = 32;
  localparam int OPA_RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_ZERO = 2'b10,
    OPA_ILL  = 2'b11
  } opasel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } occ_state_e;

  typedef struct packed {
    logic [OPA_XLEN-1:0] op_a;
    logic [OPA_XLEN-1:0] pc;
    logic                err;
  } opa_beat_t;

endpackage

// File: rtl/opa_skid_stage_if.sv
// Decode-side operand bundle: select code, PC, rs1 read port, writeback bypass and the
// resolved beat. The master drives the operands, the slave (resolver) returns the beat.
interface opa_skid_stage_if;
  import opa_skid_stage_pkg::*;

  logic [1:0]               opasel;
  logic [OPA_XLEN-1:0]      pc;
  logic [OPA_RF_ADDR_W-1:0] rs1_addr;
  logic [OPA_XLEN-1:0]      rs1_data;
  logic                     wb_we;
  logic [OPA_RF_ADDR_W-1:0] wb_rd;
  logic [OPA_XLEN-1:0]      wb_data;
  opa_beat_t                beat;

  modport master (
    output opasel, pc, rs1_addr, rs1_data, wb_we, wb_rd, wb_data,
    input  beat
  );

  modport slave (
    input  opasel, pc, rs1_addr, rs1_data, wb_we, wb_rd, wb_data,
    output beat
  );
endinterface

// File: rtl/opa_skid_stage_resolve.sv
// Combinational operand-A resolution. Writeback bypass of rs1 is built only when
// OPA_WB_FWD_EN is defined; otherwise the wb_* operands are ignored.
module opa_resolve
  import opa_skid_stage_pkg::*;
(
  opa_skid_stage_if.slave bus
);

  logic [OPA_XLEN-1:0] rs1_val;

`ifdef OPA_WB_FWD_EN
  // x0 is hardwired zero, so a write to it must never be bypassed.
  always_comb begin
    rs1_val = bus.rs1_data;
    if (bus.wb_we && (bus.wb_rd == bus.rs1_addr) && (bus.rs1_addr != '0)) begin
      rs1_val = bus.wb_data;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data, bus.rs1_addr};
  assign rs1_val   = bus.rs1_data;
`endif

  always_comb begin
    bus.beat.pc   = bus.pc;
    bus.beat.op_a = '0;
    bus.beat.err  = 1'b0;
    case (opasel_e'(bus.opasel))
      OPA_RS1:  bus.beat.op_a = rs1_val;
      OPA_PC:   bus.beat.op_a = bus.pc;
      OPA_ZERO: bus.beat.op_a = '0;
      OPA_ILL:  bus.beat.err  = 1'b1;
      default:  bus.beat.err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/opa_skid_stage.sv
// Operand-A decode->execute stage: resolves operand A at capture and holds it in a
// 2-entry skid buffer (main + skid). Optional writeback bypass: OPA_WB_FWD_EN.
module opa_skid_stage
  import opa_skid_stage_pkg::*;
#(
  // Beat storage is sized by the package; these must stay at their defaults.
  parameter int XLEN      = OPA_XLEN,
  parameter int RF_ADDR_W = OPA_RF_ADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           opasel_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [RF_ADDR_W-1:0] rs1_addr_i,
  input  logic [XLEN-1:0]      rs1_data_i,
  input  logic                 wb_we_i,
  input  logic [RF_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      op_a_o,
  output logic [XLEN-1:0]      pc_o,
  output logic                 opasel_err_o
);

  opa_skid_stage_if res_if ();

  assign res_if.opasel   = opasel_i;
  assign res_if.pc       = pc_i;
  assign res_if.rs1_addr = rs1_addr_i;
  assign res_if.rs1_data = rs1_data_i;
  assign res_if.wb_we    = wb_we_i;
  assign res_if.wb_rd    = wb_rd_i;
  assign res_if.wb_data  = wb_data_i;

  opa_resolve u_resolve (
    .bus (res_if.slave)
  );

  // Handshake: a beat moves on a side only in a cycle where valid and ready are both
  // high at the rising edge; a presented beat stays valid and stable until drained.
  occ_state_e state_q;
  opa_beat_t  main_q;
  opa_beat_t  skid_q;
  logic       in_ready_q;
  logic       out_valid_q;

  logic accept;
  logic drain;

  assign accept = in_valid_i & in_ready_q;
  assign drain  = out_valid_q & out_ready_i;

  // Flush only clears valids; stale data sits behind out_valid_o=0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_q      <= res_if.beat;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !drain) begin
            skid_q     <= res_if.beat;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (accept && drain) begin
            main_q <= res_if.beat;
          end else if (drain) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_q     <= skid_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign op_a_o       = main_q.op_a;
  assign pc_o         = main_q.pc;
  assign opasel_err_o = main_q.err;

endmodule
